branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the pipelined 16-bit datapath. The current pipeline effectively predicts not-taken and flushes IF/ID whenever a branch or jump resolves taken in EX. This block adds a prediction at IF: the fetch stage looks up the PC and fetches the predicted target. EX then reports the resolved outcome back, and the block trains its table and flags mispredictions.

## Interface
- WORD_SIZE, 16: PC/target width.
- ENTRIES, 16: table depth; power of two, ≥2. IDX = log2(ENTRIES).
- CNT_BITS, 2: direction counter width, ≥1.
- MODE, 2: 0 = static not-taken (table ignored), 1 = BTB-only (hit ⇒ taken), 2 = BTB + counters.
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- if_pc  in  WORD_SIZE  fetch PC to look up.
- pred_taken  out  1  IF prediction; combinational from if_pc and table.
- pred_target  out  WORD_SIZE  predicted target; 0 when pred_taken=0.
- ex_valid  in  1  non-bubble control-flow instruction resolved in EX this cycle.
- ex_is_jump  in  1  unconditional (JMP/JAL/JR/JRL); 0 = conditional branch.
- ex_pc  in  WORD_SIZE  PC of resolving instruction.
- ex_taken  in  1  resolved direction (1 for jumps).
- ex_target  in  WORD_SIZE  resolved target.
- ex_pred_taken, ex_pred_target  in  1, WORD_SIZE  prediction carried down the pipe with the instruction.
- mispredict  out  1  combinational; 1 when ex_valid & (ex_pred_taken≠ex_taken | (ex_taken & ex_pred_target≠ex_target)).
- redirect_pc  out  WORD_SIZE  ex_taken ? ex_target : ex_pc+1 (mod 2^WORD_SIZE); meaningful when mispredict.
- num_branches, num_mispredicts  out  WORD_SIZE  event counters.

## Operation
- Entry: valid, tag = pc[WORD_SIZE-1:IDX], target, jump flag, counter[CNT_BITS-1:0]. Index = pc[IDX-1:0].
- Lookup: hit = valid & tag match. pred_taken = MODE≠0 & hit & (MODE=1 | jump flag | counter MSB). Miss ⇒ not taken.
- Update on posedge when ex_valid & !Reset:
  - Miss & ex_taken: allocate (replace). tag, target=ex_target, jump flag=ex_is_jump, counter=weakly taken (MSB=1, others 0).
  - Miss & !ex_taken: no allocation.
  - Hit: counter saturating +1 if taken, −1 if not (holds at all-ones / zero). Target overwritten when taken. Jump flag overwritten.
  - MODE=0: table never written.
- num_branches += 1 on every ex_valid. num_mispredicts += 1 when mispredict. Both wrap 2^WORD_SIZE−1 → 0.
- Reset: all valid bits, counters, targets, and both event counters cleared. An ex_valid in the same cycle is dropped; no write, no count.
- Reset output values: pred_taken=0, pred_target=0, num_*=0. mispredict/redirect_pc follow inputs only.

## Timing
- Lookup: zero latency, same cycle as if_pc.
- Update written at the posedge ending the ex_valid cycle. Visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents (read-old).
- mispredict/redirect_pc valid in the ex_valid cycle. The datapath uses them to override nextPC and flush IF/ID, replacing the current flushIF/flushID path.
- Back-to-back ex_valid every cycle supported.

## Structure
- Shared header bp_defs.v (alongside opcodes.v): MODE encodings, counter init/saturation macros.
- One sub-module: bp_sat_counter (CNT_BITS-wide saturating up/down with load). It is instantiated per entry or shared by a read-modify-write.
- Table as flop arrays (no memory macro), since reset clears everything in one cycle.

## Test plan
Parameters for all scenarios: defaults, MODE=2.
- Reset, if_pc=0x0005 → pred_taken=0, pred_target=0x0000, num_branches=0.
- ex_valid, ex_pc=0x0005, branch taken to 0x0010, ex_pred_taken=0 → mispredict=1, redirect_pc=0x0010. Next cycle, if_pc=0x0005 → pred_taken=1, pred_target=0x0010. num_mispredicts=1.
- Same branch resolved not-taken twice (pred 1 then 0):
  - First: mispredict=1, redirect_pc=0x0006; counter 10→01; lookup then predicts not-taken.
  - Second: mispredict=0; counter 01→00.
- Alias: taken branch 0x0015→0x0020 after the first scenario → 0x0005 lookup misses, and 0x0015 hits with target 0x0020.
- JR at 0x0003 to 0x0040, then lookup and update at the same index in the same cycle → that cycle returns the old entry; the next cycle returns the new one. With Reset held during an ex_valid → no entry written, counters stay 0.
- MODE=0: 3 taken branches → pred_taken always 0, mispredict=1 each, num_mispredicts=3. Counter wrap: preload 0xFFFF + 1 event → 0x0000.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared defaults, mode encodings and helpers for the branch predictor slice.
package branch_predictor_pkg;

    localparam int unsigned BP_WORD_SIZE = 16;
    localparam int unsigned BP_ENTRIES   = 16;
    localparam int unsigned BP_CNT_BITS  = 2;

    localparam int unsigned BP_MODE_STATIC  = 0;
    localparam int unsigned BP_MODE_BTB     = 1;
    localparam int unsigned BP_MODE_COUNTER = 2;

    function automatic bit mode_uses_table(input int unsigned mode);
        return mode != BP_MODE_STATIC;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX resolve/feedback signals between the datapath and the predictor.
interface branch_predictor_if
    import branch_predictor_pkg::*;
#(
    parameter int unsigned WORD_SIZE = BP_WORD_SIZE
);
    logic [WORD_SIZE-1:0] if_pc;
    logic                 pred_taken;
    logic [WORD_SIZE-1:0] pred_target;

    logic                 ex_valid;
    logic                 ex_is_jump;
    logic [WORD_SIZE-1:0] ex_pc;
    logic                 ex_taken;
    logic [WORD_SIZE-1:0] ex_target;
    logic                 ex_pred_taken;
    logic [WORD_SIZE-1:0] ex_pred_target;

    logic                 mispredict;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic [WORD_SIZE-1:0] num_branches;
    logic [WORD_SIZE-1:0] num_mispredicts;

    modport master (
        output if_pc, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               num_branches, num_mispredicts
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_jump, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               num_branches, num_mispredicts
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for a saturating up/down direction counter with load.
module branch_predictor_sat_counter
    import branch_predictor_pkg::*;
#(
    parameter int unsigned CNT_BITS = BP_CNT_BITS
) (
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    input  logic                up,
    output logic [CNT_BITS-1:0] cnt_next_c
);
    always_comb begin
        cnt_next_c = cnt;
        if (load) begin
            cnt_next_c = load_val;
        end else if (up) begin
            if (cnt != '1) cnt_next_c = cnt + CNT_BITS'(1);
        end else begin
            if (cnt != '0) cnt_next_c = cnt - CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters.
// Zero-latency lookup at IF; training and mispredict detection from EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned WORD_SIZE = BP_WORD_SIZE,
    parameter int unsigned ENTRIES   = BP_ENTRIES,
    parameter int unsigned CNT_BITS  = BP_CNT_BITS,
    parameter int unsigned MODE      = BP_MODE_COUNTER
) (
    input logic               Clk,
    input logic               Reset,
    branch_predictor_if.slave bus
);
    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WORD_SIZE - IDX;
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam bit USE_TABLE = mode_uses_table(MODE);
    localparam bit USE_CNT   = (MODE == BP_MODE_COUNTER);

    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   jump_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [WORD_SIZE-1:0] target_q [ENTRIES];
    logic [CNT_BITS-1:0]  cnt_q    [ENTRIES];
    logic [WORD_SIZE-1:0] num_branches_q;
    logic [WORD_SIZE-1:0] num_mispredicts_q;

    logic [IDX-1:0]       rd_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_hit;
    logic                 rd_dir;
    logic                 pred_taken_c;

    logic [IDX-1:0]       wr_idx;
    logic [TAG_W-1:0]     wr_tag;
    logic                 wr_hit;
    logic                 table_we;
    logic [CNT_BITS-1:0]  cnt_next_c;
    logic                 mispredict_c;

    // Fetch lookup reads the registered table, so a same-cycle update is not visible.
    always_comb begin
        rd_idx       = bus.if_pc[IDX-1:0];
        rd_tag       = bus.if_pc[WORD_SIZE-1:IDX];
        rd_hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_dir       = !USE_CNT || jump_q[rd_idx] || cnt_q[rd_idx][CNT_BITS-1];
        pred_taken_c = USE_TABLE && rd_hit && rd_dir;
    end

    assign bus.pred_taken  = pred_taken_c;
    assign bus.pred_target = pred_taken_c ? target_q[rd_idx] : '0;

    assign wr_idx   = bus.ex_pc[IDX-1:0];
    assign wr_tag   = bus.ex_pc[WORD_SIZE-1:IDX];
    assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign table_we = USE_TABLE && bus.ex_valid && (wr_hit || bus.ex_taken);

    // Single shared counter updater: read-modify-write of the resolving entry.
    branch_predictor_sat_counter #(
        .CNT_BITS(CNT_BITS)
    ) u_sat_counter (
        .cnt       (cnt_q[wr_idx]),
        .load      (!wr_hit),
        .load_val  (CNT_INIT),
        .up        (bus.ex_taken),
        .cnt_next_c(cnt_next_c)
    );

    assign mispredict_c = bus.ex_valid &&
                          ((bus.ex_pred_taken != bus.ex_taken) ||
                           (bus.ex_taken && (bus.ex_pred_target != bus.ex_target)));
    assign bus.mispredict  = mispredict_c;
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + WORD_SIZE'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= '0;
            jump_q  <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else if (table_we) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            jump_q[wr_idx]  <= bus.ex_is_jump;
            cnt_q[wr_idx]   <= cnt_next_c;
            if (bus.ex_taken) target_q[wr_idx] <= bus.ex_target;
        end
    end

    // Event counters wrap naturally at the word width.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            num_branches_q    <= '0;
            num_mispredicts_q <= '0;
        end else if (bus.ex_valid) begin
            num_branches_q <= num_branches_q + WORD_SIZE'(1);
            if (mispredict_c) num_mispredicts_q <= num_mispredicts_q + WORD_SIZE'(1);
        end
    end

    assign bus.num_branches    = num_branches_q;
    assign bus.num_mispredicts = num_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors for MODE=2 and MODE=0 instances.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int S_PT    = 0;
    localparam int S_PTG   = 1;
    localparam int S_MIS   = 2;
    localparam int S_RED   = 3;
    localparam int S_NBR   = 4;
    localparam int S_NMIS  = 5;
    localparam int S_PT0   = 6;
    localparam int S_MIS0  = 7;
    localparam int S_NBR0  = 8;
    localparam int S_NMIS0 = 9;

    localparam int TIMEOUT = 5000000;

    typedef struct {
        string       name;
        int          sig;
        logic [15:0] exp;
    } exp_t;

    logic Clk;
    logic Reset;

    branch_predictor_if bus ();
    branch_predictor_if bus0 ();

    branch_predictor #(.MODE(BP_MODE_COUNTER)) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    branch_predictor #(.MODE(BP_MODE_STATIC)) dut0 (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus0)
    );

    exp_t        sb[$];
    exp_t        cur;
    logic [15:0] act;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          done     = 1'b0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Watchdog: an expired wait is a failure.
    initial begin
        #(TIMEOUT);
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: stimulus did not finish within %0d time units", TIMEOUT);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    function automatic logic [15:0] sig_val(input int s);
        case (s)
            S_PT:    return 16'(bus.pred_taken);
            S_PTG:   return bus.pred_target;
            S_MIS:   return 16'(bus.mispredict);
            S_RED:   return bus.redirect_pc;
            S_NBR:   return bus.num_branches;
            S_NMIS:  return bus.num_mispredicts;
            S_PT0:   return 16'(bus0.pred_taken);
            S_MIS0:  return 16'(bus0.mispredict);
            S_NBR0:  return bus0.num_branches;
            S_NMIS0: return bus0.num_mispredicts;
            default: return 16'hxxxx;
        endcase
    endfunction

    // Monitor: compare everything queued for this cycle, away from the active edge.
    always @(negedge Clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = sig_val(cur.sig);
            n_checks++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: actual 0x%04h required 0x%04h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string n, input int s, input logic [15:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Immediate comparison of a sampled value.
    task automatic chk_now(input string n, input logic [15:0] a, input logic [15:0] v);
        n_checks++;
        if (a !== v) begin
            n_fail++;
            $display("FAIL %s: actual 0x%04h required 0x%04h", n, a, v);
        end
    endtask

    task automatic idle();
        bus.ex_valid       = 1'b0;
        bus.ex_is_jump     = 1'b0;
        bus.ex_pc          = 16'h0000;
        bus.ex_taken       = 1'b0;
        bus.ex_target      = 16'h0000;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = 16'h0000;
    endtask

    task automatic idle0();
        bus0.ex_valid       = 1'b0;
        bus0.ex_is_jump     = 1'b0;
        bus0.ex_pc          = 16'h0000;
        bus0.ex_taken       = 1'b0;
        bus0.ex_target      = 16'h0000;
        bus0.ex_pred_taken  = 1'b0;
        bus0.ex_pred_target = 16'h0000;
    endtask

    task automatic ex(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                      input logic jmp, input logic ptk, input logic [15:0] ptg);
        bus.ex_valid       = 1'b1;
        bus.ex_pc          = pc;
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        bus.ex_is_jump     = jmp;
        bus.ex_pred_taken  = ptk;
        bus.ex_pred_target = ptg;
    endtask

    task automatic ex0(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        bus0.ex_valid       = 1'b1;
        bus0.ex_pc          = pc;
        bus0.ex_taken       = tk;
        bus0.ex_target      = tgt;
        bus0.ex_is_jump     = 1'b0;
        bus0.ex_pred_taken  = 1'b0;
        bus0.ex_pred_target = 16'h0000;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        idle0();
        bus.if_pc  = 16'h0005;
        bus0.if_pc = 16'h0005;
        cyc();
        chk_now("rst_now_pred_taken", 16'(bus.pred_taken), 16'h0000);
        chk_now("rst_now_pred_target", bus.pred_target, 16'h0000);
        chk_now("rst_now_num_branches", bus.num_branches, 16'h0000);
        chk_now("rst_now_num_mispredicts", bus.num_mispredicts, 16'h0000);
        chk("rst_pred_taken", S_PT, 16'h0000);
        chk("rst_pred_target", S_PTG, 16'h0000);
        chk("rst_num_branches", S_NBR, 16'h0000);
        chk("rst_num_mispredicts", S_NMIS, 16'h0000);
        chk("rst_pred_taken_m0", S_PT0, 16'h0000);
        cyc();
        Reset = 1'b0;

        // First taken branch allocates; lookup in the same cycle still misses.
        ex(16'h0005, 1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000);
        chk("alloc_mispredict", S_MIS, 16'h0001);
        chk("alloc_redirect", S_RED, 16'h0010);
        chk("alloc_same_cycle_miss", S_PT, 16'h0000);
        cyc();
        idle();
        chk("alloc_hit_taken", S_PT, 16'h0001);
        chk("alloc_hit_target", S_PTG, 16'h0010);
        chk("alloc_num_mispredicts", S_NMIS, 16'h0001);
        chk("alloc_num_branches", S_NBR, 16'h0001);
        cyc();

        // Alias at the same index with a different tag replaces the entry.
        ex(16'h0015, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000);
        bus.if_pc = 16'h0015;
        chk("alias_mispredict", S_MIS, 16'h0001);
        chk("alias_redirect", S_RED, 16'h0020);
        chk("alias_pre_miss", S_PT, 16'h0000);
        cyc();
        idle();
        bus.if_pc = 16'h0005;
        chk("alias_old_pc_miss", S_PT, 16'h0000);
        chk("alias_old_pc_target", S_PTG, 16'h0000);
        cyc();
        bus.if_pc = 16'h0015;
        chk("alias_new_hit", S_PT, 16'h0001);
        chk("alias_new_target", S_PTG, 16'h0020);
        cyc();

        // Not-taken twice: 10 -> 01 -> 00.
        ex(16'h0015, 1'b0, 16'h0020, 1'b0, 1'b1, 16'h0020);
        chk("nt1_mispredict", S_MIS, 16'h0001);
        chk("nt1_redirect", S_RED, 16'h0016);
        chk("nt1_lookup_old", S_PT, 16'h0001);
        cyc();
        ex(16'h0015, 1'b0, 16'h0020, 1'b0, 1'b0, 16'h0000);
        chk("nt2_lookup_weak_nt", S_PT, 16'h0000);
        chk("nt2_no_mispredict", S_MIS, 16'h0000);
        chk("nt2_redirect", S_RED, 16'h0016);
        cyc();

        // Climb 00 -> 01 -> 10 -> 11, then saturate and step back down.
        ex(16'h0015, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000);
        chk("up1_lookup_cnt00", S_PT, 16'h0000);
        chk("up1_mispredict", S_MIS, 16'h0001);
        cyc();
        ex(16'h0015, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000);
        chk("up2_lookup_cnt01", S_PT, 16'h0000);
        chk("up2_mispredict", S_MIS, 16'h0001);
        cyc();
        ex(16'h0015, 1'b1, 16'h0020, 1'b0, 1'b1, 16'h0020);
        chk("up3_lookup_cnt10", S_PT, 16'h0001);
        chk("up3_no_mispredict", S_MIS, 16'h0000);
        cyc();
        ex(16'h0015, 1'b1, 16'h0024, 1'b0, 1'b1, 16'h0020);
        chk("sat_lookup_target_old", S_PTG, 16'h0020);
        chk("target_mismatch_mispredict", S_MIS, 16'h0001);
        chk("target_mismatch_redirect", S_RED, 16'h0024);
        cyc();
        ex(16'h0015, 1'b0, 16'h0024, 1'b0, 1'b1, 16'h0024);
        chk("sat_lookup_cnt11", S_PT, 16'h0001);
        chk("retarget_lookup", S_PTG, 16'h0024);
        chk("down_mispredict", S_MIS, 16'h0001);
        chk("down_redirect", S_RED, 16'h0016);
        cyc();
        idle();
        chk("down_lookup_cnt10", S_PT, 16'h0001);
        chk("down_lookup_target", S_PTG, 16'h0024);
        chk("mid_num_branches", S_NBR, 16'h0009);
        chk("mid_num_mispredicts", S_NMIS, 16'h0007);
        cyc();

        // JR install, then same-index lookup during a second update sees old contents.
        ex(16'h0003, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0000);
        bus.if_pc = 16'h0003;
        chk("jr_same_cycle_empty", S_PT, 16'h0000);
        chk("jr_mispredict", S_MIS, 16'h0001);
        chk("jr_redirect", S_RED, 16'h0040);
        cyc();
        ex(16'h0003, 1'b1, 16'h0050, 1'b1, 1'b1, 16'h0040);
        chk("rmw_read_old_taken", S_PT, 16'h0001);
        chk("rmw_read_old_target", S_PTG, 16'h0040);
        chk("rmw_mispredict", S_MIS, 16'h0001);
        chk("rmw_redirect", S_RED, 16'h0050);
        cyc();
        idle();
        chk("rmw_new_taken", S_PT, 16'h0001);
        chk("rmw_new_target", S_PTG, 16'h0050);
        chk("jr_num_branches", S_NBR, 16'h000b);
        chk("jr_num_mispredicts", S_NMIS, 16'h0009);
        cyc();

        // Reset held during an ex_valid: outputs still follow inputs, nothing is recorded.
        Reset = 1'b1;
        ex(16'h0008, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0000);
        chk("rst_ex_mispredict", S_MIS, 16'h0001);
        chk("rst_ex_redirect", S_RED, 16'h0080);
        cyc();
        Reset = 1'b0;
        idle();
        bus.if_pc = 16'h0008;
        chk("rst_ex_no_alloc", S_PT, 16'h0000);
        chk("rst_ex_num_branches", S_NBR, 16'h0000);
        chk("rst_ex_num_mispredicts", S_NMIS, 16'h0000);
        cyc();
        bus.if_pc = 16'h0003;
        chk("rst_cleared_taken", S_PT, 16'h0000);
        chk("rst_cleared_target", S_PTG, 16'h0000);
        cyc();

        // Static not-taken instance ignores its table.
        for (int i = 0; i < 3; i++) begin
            ex0(16'h0005, 1'b1, 16'h0010);
            chk("m0_pred_taken", S_PT0, 16'h0000);
            chk("m0_mispredict", S_MIS0, 16'h0001);
            cyc();
        end
        idle0();
        chk("m0_after_pred_taken", S_PT0, 16'h0000);
        chk("m0_num_mispredicts", S_NMIS0, 16'h0003);
        chk("m0_num_branches", S_NBR0, 16'h0003);
        cyc();

        // Counter wrap: 65535 correctly predicted not-taken events, then one more.
        bus.if_pc = 16'h0000;
        for (int i = 0; i < 65535; i++) begin
            ex(16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            cyc();
        end
        idle();
        chk("wrap_pre_num_branches", S_NBR, 16'hffff);
        chk("wrap_pre_num_mispredicts", S_NMIS, 16'h0000);
        cyc();
        ex(16'h0009, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("wrap_no_mispredict", S_MIS, 16'h0000);
        chk("wrap_redirect", S_RED, 16'h000a);
        cyc();
        idle();
        chk("wrap_num_branches", S_NBR, 16'h0000);
        chk("wrap_num_mispredicts", S_NMIS, 16'h0000);
        cyc();

        @(negedge Clk);
        #1;
        done = 1'b1;
        if (n_fail != 0) $display("FAIL: %0d check(s) failed", n_fail);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
